// File: rtl/time_disp_pkg.sv
// time_disp_pkg: shared constants for the clock display path
// (segment codes, digit slot indices, blink field encodings).
`default_nettype none

package time_disp_pkg;

  // Active-low segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [2:0] DIG_HH = 3'd0;
  localparam logic [2:0] DIG_HL = 3'd1;
  localparam logic [2:0] DIG_MH = 3'd2;
  localparam logic [2:0] DIG_ML = 3'd3;
  localparam logic [2:0] DIG_SH = 3'd4;
  localparam logic [2:0] DIG_SL = 3'd5;

  typedef enum logic [1:0] {
    BLINK_NONE = 2'd0,
    BLINK_HOUR = 2'd1,
    BLINK_MIN  = 2'd2,
    BLINK_SEC  = 2'd3
  } blink_sel_t;

  // Which blink field a digit slot belongs to
  function automatic blink_sel_t field_of(input logic [2:0] idx);
    case (idx)
      DIG_HH, DIG_HL: field_of = BLINK_HOUR;
      DIG_MH, DIG_ML: field_of = BLINK_MIN;
      DIG_SH, DIG_SL: field_of = BLINK_SEC;
      default:        field_of = BLINK_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_decode.sv
// seg7_decode: 4-bit BCD to active-low seven-segment code; values above 9
// render as a dash.
`default_nettype none

module seg7_decode
  import time_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/time_scan_display.sv
// time_scan_display: six-digit multiplexed seven-segment scanner with
// frame snapshot, leading-zero blanking, field blink and flashing separator.
`default_nettype none

module time_scan_display
  import time_disp_pkg::*;
#(
  parameter int SCAN_DIV     = 5000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic [3:0] hour_high,
  input  logic [3:0] hour_low,
  input  logic [3:0] min_high,
  input  logic [3:0] min_low,
  input  logic [3:0] sec_high,
  input  logic [3:0] sec_low,
  input  logic [1:0] blink_sel,
  input  logic       lz_blank,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] dig,
  output logic       frame
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FR_LAST  = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0] pre;
  logic [2:0]    idx;
  logic [FW-1:0] fcnt;
  logic          phase;
  logic [3:0]    snap_hh, snap_hl, snap_mh, snap_ml, snap_sh, snap_sl;

  logic          pre_wrap;
  logic          frame_evt;
  logic          ghost;
  logic          blink_hit;
  logic          lz_hit;
  logic [3:0]    cur_digit;
  logic [6:0]    dec_seg;
  logic [6:0]    seg_nxt;
  logic          dp_nxt;
  logic [5:0]    dig_nxt;

  assign pre_wrap  = (pre == PRE_LAST);
  assign frame_evt = pre_wrap && (idx == DIG_SL);

  always_comb begin
    cur_digit = 4'd0;
    case (idx)
      DIG_HH:  cur_digit = snap_hh;
      DIG_HL:  cur_digit = snap_hl;
      DIG_MH:  cur_digit = snap_mh;
      DIG_ML:  cur_digit = snap_ml;
      DIG_SH:  cur_digit = snap_sh;
      DIG_SL:  cur_digit = snap_sl;
      default: cur_digit = 4'd0;
    endcase
  end

  seg7_decode u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  // The first cycle of every slot drives nothing so the previous digit's
  // segments never bleed onto the newly enabled digit.
  always_comb begin
    ghost     = (pre == '0);
    blink_hit = phase && (blink_sel != BLINK_NONE) && (blink_sel == field_of(idx));
    lz_hit    = (idx == DIG_HH) && lz_blank && (snap_hh == 4'd0);

    seg_nxt = SEG_BLANK;
    dp_nxt  = 1'b1;
    dig_nxt = 6'h3F;
    if (!ghost) begin
      dig_nxt = 6'h3F & ~(6'b000001 << idx);
      if (blink_hit || lz_hit) begin
        seg_nxt = SEG_BLANK;
      end else begin
        seg_nxt = dec_seg;
      end
      if (!phase && ((idx == DIG_HL) || (idx == DIG_ML))) begin
        dp_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clkin) begin
    if (rst) begin
      pre     <= '0;
      idx     <= DIG_HH;
      fcnt    <= '0;
      phase   <= 1'b0;
      snap_hh <= 4'd0;
      snap_hl <= 4'd0;
      snap_mh <= 4'd0;
      snap_ml <= 4'd0;
      snap_sh <= 4'd0;
      snap_sl <= 4'd0;
      seg     <= SEG_BLANK;
      dp      <= 1'b1;
      dig     <= 6'h3F;
      frame   <= 1'b0;
    end else begin
      pre <= pre_wrap ? '0 : pre + PW'(1);
      if (pre_wrap) begin
        idx <= (idx == DIG_SL) ? DIG_HH : idx + 3'd1;
      end
      if (frame_evt) begin
        snap_hh <= hour_high;
        snap_hl <= hour_low;
        snap_mh <= min_high;
        snap_ml <= min_low;
        snap_sh <= sec_high;
        snap_sl <= sec_low;
        if (fcnt == FR_LAST) begin
          fcnt  <= '0;
          phase <= ~phase;
        end else begin
          fcnt <= fcnt + FW'(1);
        end
      end
      seg   <= seg_nxt;
      dp    <= dp_nxt;
      dig   <= dig_nxt;
      frame <= frame_evt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_time_scan_display.sv
// tb_time_scan_display: directed plus random stimulus against a cycle-count
// reference model of the scanned display.
`default_nettype none
`timescale 1ns/1ps

module tb_time_scan_display;

  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME_LEN    = 6 * SCAN_DIV;

  logic       clkin = 1'b0;
  logic       rst;
  logic [3:0] din [6];
  logic [1:0] blink_sel;
  logic       lz_blank;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] dig;
  logic       frame;

  always #5 clkin = ~clkin;

  time_scan_display #(
    .SCAN_DIV     (SCAN_DIV),
    .BLINK_FRAMES (BLINK_FRAMES)
  ) dut (
    .clkin     (clkin),
    .rst       (rst),
    .hour_high (din[0]),
    .hour_low  (din[1]),
    .min_high  (din[2]),
    .min_low   (din[3]),
    .sec_high  (din[4]),
    .sec_low   (din[5]),
    .blink_sel (blink_sel),
    .lz_blank  (lz_blank),
    .seg       (seg),
    .dp        (dp),
    .dig       (dig),
    .frame     (frame)
  );

  logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

  int         n_checks = 0;
  int         n_pass   = 0;
  int         cyc      = 0;
  int         n        = 0;   // cycles elapsed since the last reset edge
  logic [3:0] snap [6];

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %02h expected %02h", tag, cyc, obs, exp);
  endtask

  // One clock: predict the registered outputs from the state before the
  // edge, advance the model, then compare after the edge.
  task automatic step();
    int         pre, idx, phase;
    logic [6:0] e_seg;
    logic       e_dp, e_frame;
    logic [5:0] e_dig;
    pre   = n % SCAN_DIV;
    idx   = (n / SCAN_DIV) % 6;
    phase = (n / (FRAME_LEN * BLINK_FRAMES)) % 2;
    e_frame = (pre == SCAN_DIV - 1) && (idx == 5);
    if (rst) begin
      e_seg = 7'h7F; e_dp = 1'b1; e_dig = 6'h3F; e_frame = 1'b0;
    end else if (pre == 0) begin
      e_seg = 7'h7F; e_dp = 1'b1; e_dig = 6'h3F;
    end else begin
      e_dig = 6'h3F;
      e_dig[idx] = 1'b0;
      if (phase == 1 && blink_sel != 0 && (idx / 2) == int'(blink_sel) - 1)
        e_seg = 7'h7F;
      else if (idx == 0 && lz_blank && snap[0] == 4'd0)
        e_seg = 7'h7F;
      else
        e_seg = seg_ref[snap[idx]];
      e_dp = !((phase == 0) && (idx == 1 || idx == 3));
    end
    @(posedge clkin);
    if (rst) begin
      n = 0;
      for (int i = 0; i < 6; i++) snap[i] = 4'd0;
    end else begin
      if ((n % FRAME_LEN) == FRAME_LEN - 1)
        for (int i = 0; i < 6; i++) snap[i] = din[i];
      n++;
    end
    #1;
    cyc++;
    check("seg",   {1'b0, seg},   {1'b0, e_seg});
    check("dp",    {7'b0, dp},    {7'b0, e_dp});
    check("dig",   {2'b0, dig},   {2'b0, e_dig});
    check("frame", {7'b0, frame}, {7'b0, e_frame});
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  function automatic logic [3:0] rand_digit();
    if ($urandom_range(0, 7) == 0) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  initial begin
    rst = 1'b1;
    blink_sel = 2'd0;
    lz_blank  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      din[i]  = 4'(i + 1);
      snap[i] = 4'd0;
    end
    run(3);
    rst = 1'b0;
    // Basic scan, two blink periods worth of frames
    run(4 * FRAME_LEN);

    // Leading zero blanking on and off
    din[0] = 4'd0; lz_blank = 1'b1;
    run(2 * FRAME_LEN);
    lz_blank = 1'b0;
    run(FRAME_LEN);

    // Minute-field blink across both phases
    blink_sel = 2'd2;
    run(4 * FRAME_LEN);

    // Mid-frame input change, invalid BCD on seconds
    while ((n % FRAME_LEN) != 10) step();
    din[3] = 4'd7; din[5] = 4'd12;
    run(2 * FRAME_LEN);

    // Mid-scan reset at idx 3, pre 2
    while ((n % FRAME_LEN) != 3 * SCAN_DIV + 2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(2 * FRAME_LEN);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0) din[$urandom_range(0, 5)] = rand_digit();
      if ($urandom_range(0, 99) == 0) blink_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) lz_blank = ~lz_blank;
      if ($urandom_range(0, 149) == 0) din[0] = 4'd0;
      rst = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    run(FRAME_LEN);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
